// File: rtl/spatz_pkg.sv
// spatz_pkg: shared Spatz types and parameters.
// Holds the request/response structs exchanged between the decoder, the ID
// tracker and the functional units, plus the ID tracker's error-cause enum.
// Also provides the ID width `NrIdBits`, derived from the in-flight depth.
package spatz_pkg;

   localparam int unsigned NrParallelInstructions = 4;
   localparam int unsigned ELEN     = 32;
   localparam int unsigned GPRWidth = 5;
   localparam int unsigned NrIdBits = $clog2(NrParallelInstructions);

   typedef logic [NrIdBits-1:0] spatz_id_t;

   // CON covers VCFG/VCSR, which are handled by the controller itself.
   typedef enum logic [1:0] {CON, VFU, LSU, SLD} ex_unit_e;
   typedef enum logic [1:0] {VCFG, VADD, VLE, VSLIDEUP} op_e;

   typedef struct packed {
      spatz_id_t             id;
      op_e                   op;
      ex_unit_e              ex_unit;
      logic [GPRWidth-1:0]   rd;
      logic [ELEN-1:0]       rs1;
   } spatz_req_t;

   typedef struct packed {
      spatz_id_t             id;
      logic [GPRWidth-1:0]   rd;
      logic [ELEN-1:0]       result;
      logic                  wb;
   } vfu_rsp_t;

   typedef struct packed {
      spatz_id_t id;
      logic      exc;
   } vlsu_rsp_t;

   typedef struct packed {
      spatz_id_t id;
   } vsldu_rsp_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_SPURIOUS_RETIRE,
      ERR_DOUBLE_RETIRE,
      ERR_UNSTABLE_OUT
   } spatz_id_tracker_err_e;

endpackage

// File: rtl/spatz_id_alloc.sv
// spatz_id_alloc: combinational lowest-free-index finder.
// Ports:
//   busy_i      in  NrIds    busy bit per ID
//   free_id_o   out IdW      lowest-index clear bit (0 when none is clear)
//   has_free_o  out 1        at least one ID is clear
module spatz_id_alloc #(
   parameter int unsigned NrIds = 4,
   localparam int unsigned IdW  = $clog2(NrIds)
) (
   input  logic [NrIds-1:0] busy_i,
   output logic [IdW-1:0]   free_id_o,
   output logic             has_free_o
);

   // Scanning from the top down lets the lowest clear index win.
   always_comb begin
      free_id_o = '0;
      for (int i = NrIds - 1; i >= 0; i--) begin
         if (!busy_i[i]) free_id_o = IdW'(i);
      end
   end

   assign has_free_o = ~&busy_i;

endmodule

// File: rtl/spatz_id_tracker.sv
// spatz_id_tracker: stamps decoded vector requests with a free ID, tracks
// in-flight IDs and frees them on VFU/VLSU/VSLDU responses. Back-pressures
// the decoder when every ID is in use; CON requests bypass allocation.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   req_valid_i/req_ready_o/req_i  decoder side (id field ignored)
//   req_valid_o/req_ready_i/req_o  dispatch side, one-entry output register
//   vfu/vlsu/vsldu_rsp_valid_i/_i  retire strobes carrying the ID to free
//   wb_valid_o/wb_rd_o/wb_data_o   registered scalar write-back pulse
//   exc_o                          registered VLSU exception pulse
//   inflight_o                     number of busy IDs
//   busy_o                         any ID busy or output pending
//   err_o                          sticky protocol error
// Macro SPATZ_ID_TRACK_CHECK_EN enables the protocol checker behind err_o
// together with matching simulation assertions; without it err_o is 0.
// NrIds must be a power of two, at least 2, and not above
// NrParallelInstructions (IDs travel in spatz_id_t).
module spatz_id_tracker
   import spatz_pkg::*;
#(
   parameter int unsigned NrIds = NrParallelInstructions,
   localparam int unsigned IdW  = $clog2(NrIds),
   localparam int unsigned CntW = $clog2(NrIds + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  spatz_req_t          req_i,
   output logic                req_valid_o,
   input  logic                req_ready_i,
   output spatz_req_t          req_o,
   input  logic                vfu_rsp_valid_i,
   input  vfu_rsp_t            vfu_rsp_i,
   input  logic                vlsu_rsp_valid_i,
   input  vlsu_rsp_t           vlsu_rsp_i,
   input  logic                vsldu_rsp_valid_i,
   input  vsldu_rsp_t          vsldu_rsp_i,
   output logic                wb_valid_o,
   output logic [GPRWidth-1:0] wb_rd_o,
   output logic [ELEN-1:0]     wb_data_o,
   output logic                exc_o,
   output logic [CntW-1:0]     inflight_o,
   output logic                busy_o,
   output logic                err_o
);

   logic [NrIds-1:0]    busy_q, busy_d, alloc_set, retire_clr;
   logic                out_valid_q, out_valid_d;
   spatz_req_t          out_req_q, out_req_d;
   logic                wb_valid_q, exc_q;
   logic [GPRWidth-1:0] wb_rd_q;
   logic [ELEN-1:0]     wb_data_q;
   logic [IdW-1:0]      free_id;
   logic                has_free, is_con, accept;
   logic [CntW-1:0]     cnt;

   spatz_id_alloc #(.NrIds(NrIds)) i_alloc (
      .busy_i     (busy_q),
      .free_id_o  (free_id),
      .has_free_o (has_free)
   );

   assign is_con      = (req_i.ex_unit == CON);
   assign req_ready_o = (!out_valid_q || req_ready_i) && (is_con || has_free);
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      alloc_set  = '0;
      retire_clr = '0;
      if (accept && !is_con)  alloc_set[free_id]            = 1'b1;
      if (vfu_rsp_valid_i)    retire_clr[vfu_rsp_i.id]      = 1'b1;
      if (vlsu_rsp_valid_i)   retire_clr[vlsu_rsp_i.id]     = 1'b1;
      if (vsldu_rsp_valid_i)  retire_clr[vsldu_rsp_i.id]    = 1'b1;
      // Allocation picks a clear bit of busy_q, so a legal retire never
      // targets the bit being set; order of the merge is irrelevant.
      busy_d = (busy_q & ~retire_clr) | alloc_set;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_req_d   = out_req_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_req_d    = req_i;
         out_req_d.id = is_con ? '0 : spatz_id_t'(free_id);
      end else if (req_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q      <= '0;
         out_valid_q <= 1'b0;
         out_req_q   <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         exc_q       <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_req_q   <= out_req_d;
         wb_valid_q  <= vfu_rsp_valid_i && vfu_rsp_i.wb;
         exc_q       <= vlsu_rsp_valid_i && vlsu_rsp_i.exc;
         if (vfu_rsp_valid_i && vfu_rsp_i.wb) begin
            wb_rd_q   <= vfu_rsp_i.rd;
            wb_data_q <= vfu_rsp_i.result;
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < NrIds; i++) cnt = cnt + CntW'(busy_q[i]);
   end

   assign req_valid_o = out_valid_q;
   assign req_o       = out_req_q;
   assign wb_valid_o  = wb_valid_q;
   assign wb_rd_o     = wb_rd_q;
   assign wb_data_o   = wb_data_q;
   assign exc_o       = exc_q;
   assign inflight_o  = cnt;
   assign busy_o      = (|busy_q) || out_valid_q;

`ifdef SPATZ_ID_TRACK_CHECK_EN
   logic       err_q, stall_q;
   spatz_req_t prev_req_q;
   logic       spurious, double_ret, unstable;

   assign spurious = (vfu_rsp_valid_i   && !busy_q[vfu_rsp_i.id])
                  || (vlsu_rsp_valid_i  && !busy_q[vlsu_rsp_i.id])
                  || (vsldu_rsp_valid_i && !busy_q[vsldu_rsp_i.id]);
   assign double_ret =
        (vfu_rsp_valid_i  && vlsu_rsp_valid_i  && vfu_rsp_i.id  == vlsu_rsp_i.id)
     || (vfu_rsp_valid_i  && vsldu_rsp_valid_i && vfu_rsp_i.id  == vsldu_rsp_i.id)
     || (vlsu_rsp_valid_i && vsldu_rsp_valid_i && vlsu_rsp_i.id == vsldu_rsp_i.id);
   // Compare against the value held during the previous stalled cycle.
   assign unstable = stall_q && (prev_req_q != out_req_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q      <= 1'b0;
         stall_q    <= 1'b0;
         prev_req_q <= '0;
      end else begin
         err_q      <= err_q || spurious || double_ret || unstable;
         stall_q    <= out_valid_q && !req_ready_i;
         prev_req_q <= out_req_q;
      end
   end

   assign err_o = err_q;

   a_spurious : assert property (@(posedge clk_i) disable iff (!rst_ni) !spurious);
   a_double   : assert property (@(posedge clk_i) disable iff (!rst_ni) !double_ret);
   a_unstable : assert property (@(posedge clk_i) disable iff (!rst_ni) !unstable);
`else
   assign err_o = 1'b0;
`endif

endmodule
